// File: rtl/alu_pkg.sv
// Shared opcode, field-position and FSM definitions for the instruction sequencer.
// Pure declarations; no logic, no latency.
// No flow control involved.
package alu_pkg;

    localparam int INSTR_W  = 9;
    localparam int TYPE_BIT = 8;
    localparam int R_OP_HI  = 7;
    localparam int R_OP_LO  = 4;
    localparam int REG_HI   = 3;
    localparam int REG_LO   = 0;
    localparam int I_OP_HI  = 7;
    localparam int I_OP_LO  = 5;
    localparam int IMM_HI   = 4;
    localparam int IMM_LO   = 0;

    typedef enum logic [3:0] {
        R_ADD = 4'h0,
        R_SUB = 4'h1,
        R_AND = 4'h2,
        R_OR  = 4'h3,
        R_XOR = 4'h4,
        R_SHL = 4'h5,
        R_SHR = 4'h6,
        R_MOV = 4'h7,
        R_J   = 4'hD
    } r_op_e;

    typedef enum logic [2:0] {
        I_ADDI = 3'b000,
        I_SUBI = 3'b001,
        I_ANDI = 3'b010,
        I_ORI  = 3'b011,
        I_LDI  = 3'b100,
        I_XORI = 3'b101,
        I_HALT = 3'b110,
        I_LUI  = 3'b111
    } i_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/instr_decode.sv
// Splits a 9-bit instruction word into its fields and flags HALT / carry-producing ops.
// Purely combinational, zero latency.
// No flow control.
module instr_decode
    import alu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic               type_code_o,
    output logic [3:0]         r_op_o,
    output logic [3:0]         reg_addr_o,
    output logic [2:0]         i_op_o,
    output logic [4:0]         imm_o,
    output logic               is_halt_o,
    output logic               upd_carry_o
);

    assign type_code_o = instr_i[TYPE_BIT];
    assign r_op_o      = instr_i[R_OP_HI:R_OP_LO];
    assign reg_addr_o  = instr_i[REG_HI:REG_LO];
    assign i_op_o      = instr_i[I_OP_HI:I_OP_LO];
    assign imm_o       = instr_i[IMM_HI:IMM_LO];

    // Classify the instruction: HALT is I-type only; carry is produced by add/sub of either type.
    always_comb begin
        is_halt_o   = 1'b0;
        upd_carry_o = 1'b0;
        if (type_code_o) begin
            is_halt_o   = (i_op_o == I_HALT);
            upd_carry_o = (i_op_o == I_ADDI) || (i_op_o == I_SUBI);
        end else begin
            upd_carry_o = (r_op_o == R_ADD) || (r_op_o == R_SUB);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: IDLE->FETCH->EXEC loop with branch, carry chaining and HALT; SEQ_TIMEOUT_EN adds a fetch timeout.
// Issue one cycle after imem_valid; zero-wait memory gives 2 cycles per instruction.
// FETCH stalls while imem_valid=0 (indefinitely unless SEQ_TIMEOUT_EN halts it with err after FETCH_TMO cycles).
module instr_sequencer
    import alu_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int FETCH_TMO = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [8:0]      imem_data,
    output logic            issue,
    output logic            type_code,
    output logic [3:0]      r_op,
    output logic [3:0]      reg_addr,
    output logic [2:0]      i_op,
    output logic [4:0]      imm,
    output logic            sc_in,
    input  logic            sc_out,
    input  logic            branch,
    input  logic [PC_W-1:0] branch_target,
    output logic            done,
    output logic            err
);

    seq_state_e          state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                sc_in_q, sc_in_d;
    logic                dec_halt;
    logic                dec_carry;
    logic                tmo_hit;

    // Field outputs come straight from the instruction register, so they hold between issues.
    instr_decode u_decode (
        .instr_i     (ir_q),
        .type_code_o (type_code),
        .r_op_o      (r_op),
        .reg_addr_o  (reg_addr),
        .i_op_o      (i_op),
        .imm_o       (imm),
        .is_halt_o   (dec_halt),
        .upd_carry_o (dec_carry)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(FETCH_TMO + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    assign tmo_hit = (tmo_q == TMO_W'(FETCH_TMO - 1));
    assign err     = err_q;

    // Count stalled fetch cycles; held at zero outside FETCH so every FETCH entry starts fresh.
    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q != S_FETCH) begin
            tmo_d = '0;
        end else if (!imem_valid) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_hit) begin
                err_d = 1'b1;
            end
        end
        if (state_q == S_HALT && start) begin
            err_d = 1'b0;
        end
    end

    // Timeout counter and error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign issue     = (state_q == S_EXEC);
    assign done      = (state_q == S_HALT);
    assign sc_in     = sc_in_q;

    // Next-state, pc, instruction register and carry update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        sc_in_d = sc_in_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    sc_in_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                if (dec_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = branch ? branch_target : pc_q + 1'b1;
                    if (dec_carry) begin
                        sc_in_d = sc_out;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            sc_in_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            sc_in_q <= sc_in_d;
        end
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, program-counter width.
REQ-002 The block SHALL have parameter FETCH_TMO, default 15, fetch-timeout limit in cycles (used only with SEQ_TIMEOUT_EN).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  start program at PC 0
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address
- imem_valid  in  1  fetch data valid
- imem_data  in  9  instruction word
- issue  out  1  decoded fields valid, one-cycle pulse
- type_code  out  1  instr[8]; 0 R, 1 I
- r_op  out  4  instr[7:4]
- reg_addr  out  4  instr[3:0]
- i_op  out  3  instr[7:5]
- imm  out  5  instr[4:0]
- sc_in  out  1  registered carry to ALU
- sc_out  in  1  carry from ALU
- branch  in  1  ALU branch flag
- branch_target  in  PC_W  taken-branch address
- done  out  1  halted
- err  out  1  fetch timeout

Function
REQ-005 The FSM SHALL have states IDLE, FETCH, EXEC and HALT.
REQ-006 IDLE SHALL move to FETCH on start=1, with pc=0 and sc_in=0.
REQ-007 FETCH SHALL drive imem_req=1 and imem_addr=pc, then latch imem_data into the instruction register and enter EXEC on the first cycle with imem_valid=1.
REQ-008 imem_valid outside FETCH SHALL be ignored.
REQ-009 EXEC SHALL last exactly one cycle.
- issue=1 during EXEC.
- Field outputs come from the instruction register.
- All other cycles: issue=0; field outputs hold their last value.
REQ-010 HALT instruction: type_code=1 with i_op=3'b110.
- In EXEC it SHALL cause a transition to HALT with done=1.
- pc and sc_in SHALL be left unchanged.
REQ-011 Otherwise, at the end of EXEC, pc SHALL load branch_target if branch=1, else pc+1 modulo 2^PC_W, and the FSM SHALL return to FETCH.
- Wrap: pc from 2^PC_W-1 goes to 0.
REQ-012 sc_in SHALL be updated from sc_out at the end of EXEC only for R ADD/SUB (r_op 0000/0001) and I ADDI/SUBI (i_op 000/001); otherwise it SHALL be held.
REQ-013 Fetch-to-issue latency SHALL be 1 cycle after imem_valid; a zero-wait memory gives 2 cycles per instruction.
REQ-014 HALT SHALL move to FETCH on start=1, with pc=0, sc_in=0, done=0, err=0.
REQ-015 start SHALL be ignored in FETCH and EXEC.
REQ-016 branch and sc_out SHALL be sampled only in EXEC.

Reset
REQ-017 Reset, including assertion mid-fetch or mid-EXEC, SHALL immediately force:
- state IDLE, pc=0, instruction register=0, sc_in=0
- imem_req=0, issue=0, done=0, err=0, timeout counter=0
- field outputs=0

Configuration
REQ-018 With macro SEQ_TIMEOUT_EN defined:
- A counter SHALL count FETCH cycles with imem_valid=0.
- When it reaches FETCH_TMO, the FSM SHALL enter HALT with done=1 and err=1.
- The counter SHALL clear on entry to FETCH.
REQ-019 Without SEQ_TIMEOUT_EN, FETCH SHALL wait indefinitely, err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-020 Shared package alu_pkg SHALL hold:
- R-op and I-op enumerations, including HALT = 3'b110
- the FSM state typedef
- instruction width (9) and field position constants
REQ-021 A combinational sub-module instr_decode SHALL split the instruction register into the field outputs and flag HALT and carry-updating ops.

Verification
REQ-022 Reset, start=1, zero-wait memory returning 9'h104 (I ADDI imm 4) -> issue in the cycle after imem_valid; type_code=1, i_op=000, imm=4; pc becomes 1.
REQ-023 R ADD (9'h003) with sc_out=1 in EXEC -> sc_in=1 from the next cycle; following ANDI (9'h140) with sc_out=0 -> sc_in stays 1.
REQ-024 Instruction J (9'h0D0) with branch=1, branch_target=10'h155 -> next imem_addr=10'h155; with branch=0 -> pc+1.
REQ-025 pc=10'h3FF, non-branch instruction -> next imem_addr=10'h000.
REQ-026 HALT word 9'h1C0 -> done=1, imem_req=0; start=1 -> refetch from address 0, done=0.
REQ-027 Reset asserted while imem_req=1 and waiting; with SEQ_TIMEOUT_EN, imem_valid held 0 for 15 cycles -> done=1, err=1.
- First case -> all outputs 0 asynchronously.
- Second case -> without the macro, FETCH persists.
